// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: state encoding, melody ids,
// ROM entry layout, note divider constants and ROM helper functions.
package melody_pkg;

  localparam int ID_W       = 3;
  localparam int NOTE_IDX_W = 2;
  localparam int ADDR_W     = 4;
  localparam int DIV_W      = 18;
  localparam int DUR_W      = 4;

  // FSM encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_PLAY = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Melody ids; anything from 4 up has no table entry
  localparam logic [ID_W-1:0] ID_SPIN  = 3'd0;
  localparam logic [ID_W-1:0] ID_WIN   = 3'd1;
  localparam logic [ID_W-1:0] ID_LOSE  = 3'd2;
  localparam logic [ID_W-1:0] ID_CLEAR = 3'd3;

  // Start address reported for ids without a melody
  localparam logic [ADDR_W-1:0] ADDR_NONE = 4'hF;

  // Half-period dividers
  localparam logic [DIV_W-1:0] N30000 = 18'd30000;
  localparam logic [DIV_W-1:0] N35000 = 18'd35000;
  localparam logic [DIV_W-1:0] N45000 = 18'd45000;
  localparam logic [DIV_W-1:0] N50000 = 18'd50000;
  localparam logic [DIV_W-1:0] N70000 = 18'd70000;
  localparam logic [DIV_W-1:0] N90000 = 18'd90000;
  localparam logic [DIV_W-1:0] N_REST = 18'd0;

  typedef struct packed {
    logic             last;
    logic [DIV_W-1:0] divider;
    logic [DUR_W-1:0] dur;
  } entry_t;

  function automatic entry_t mk_entry(input logic last, input logic [DIV_W-1:0] div,
                                      input logic [DUR_W-1:0] dur);
    entry_t e;
    e.last    = last;
    e.divider = div;
    e.dur     = dur;
    return e;
  endfunction

  function automatic logic [ADDR_W-1:0] melody_start(input logic [ID_W-1:0] id);
    logic [ADDR_W-1:0] a;
    case (id)
      ID_SPIN:  a = 4'd0;
      ID_WIN:   a = 4'd1;
      ID_LOSE:  a = 4'd4;
      ID_CLEAR: a = 4'd7;
      default:  a = ADDR_NONE;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Request/status/tone bundle between a host and the melody sequencer.
interface melody_sequencer_if;
  import melody_pkg::*;

  logic            play_req;
  logic [ID_W-1:0] play_id;
  logic            abort;
  logic            play_ack;
  logic            busy;
  logic            done;
  logic [31:0]     tone_divider;
  logic            tone_on;

  modport master (output play_req, play_id, abort,
                  input  play_ack, busy, done, tone_divider, tone_on);
  modport slave  (input  play_req, play_id, abort,
                  output play_ack, busy, done, tone_divider, tone_on);
endinterface

// File: rtl/melody_rom.sv
// Note table for all melodies. Output entry and start address are registered,
// so the entry for (id, idx) is visible one cycle after it is addressed.
module melody_rom
  import melody_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       melody_id,
  input  logic [NOTE_IDX_W-1:0] note_idx,
  output entry_t                entry,
  output logic [ADDR_W-1:0]     start_addr
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] addr;
  entry_t            rd;

  // address = melody base + note index, then table lookup
  always_comb begin
    base = melody_start(melody_id);
    addr = base + ADDR_W'(note_idx);
    case (addr)
      4'd0:    rd = mk_entry(1'b1, N50000, 4'd1);
      4'd1:    rd = mk_entry(1'b0, N35000, 4'd1);
      4'd2:    rd = mk_entry(1'b0, N50000, 4'd1);
      4'd3:    rd = mk_entry(1'b1, N70000, 4'd1);
      4'd4:    rd = mk_entry(1'b0, N90000, 4'd8);
      4'd5:    rd = mk_entry(1'b0, N_REST, 4'd8);
      4'd6:    rd = mk_entry(1'b1, N90000, 4'd8);
      4'd7:    rd = mk_entry(1'b0, N30000, 4'd4);
      4'd8:    rd = mk_entry(1'b0, N35000, 4'd4);
      4'd9:    rd = mk_entry(1'b0, N30000, 4'd4);
      4'd10:   rd = mk_entry(1'b1, N45000, 4'd4);
      default: rd = mk_entry(1'b0, N_REST, 4'd0);
    endcase
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      entry      <= '0;
      start_addr <= '0;
    end else begin
      entry      <= rd;
      start_addr <= base;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: plays a selected melody from melody_rom as a sequence of
// buzzer dividers with a silent gap after each note.
// Optional build macro MELODY_SEQUENCER_LOOP_EN: melody id0 repeats until abort.
//
// Gap timing: the LOAD cycle between two notes is silent, so the GAP state
// runs GAP_CYC-1 cycles before a LOAD and a full GAP_CYC before DONE; every
// note is therefore followed by exactly GAP_CYC silent cycles.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int TICK_CYC = 131072,
  parameter int GAP_CYC  = 4096
) (
  input logic               clk,
  input logic               rst,
  melody_sequencer_if.slave bus
);

  localparam int PLAY_MAX = 16 * TICK_CYC;
  localparam int CNT_MAX  = (PLAY_MAX > GAP_CYC) ? PLAY_MAX : GAP_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [ID_W-1:0]       id_q;
  logic [NOTE_IDX_W-1:0] idx;
  logic [DIV_W-1:0]      div_q;
  logic                  last_q;
  logic                  play_ack_q;

  entry_t                rom_entry;
  logic [ADDR_W-1:0]     rom_start;
  logic [ID_W-1:0]       rom_id;
  logic [NOTE_IDX_W-1:0] rom_idx;
  logic                  accept;
  logic                  loop_id;
  logic [CNT_W-1:0]      play_len;
  logic [CNT_W-1:0]      gap_len;

  // while idle the ROM is pointed at the first note of the requested melody
  assign rom_id  = (state == ST_IDLE) ? bus.play_id : id_q;
  assign rom_idx = (state == ST_IDLE) ? '0 : idx;

  melody_rom u_rom (
    .clk        (clk),
    .rst        (rst),
    .melody_id  (rom_id),
    .note_idx   (rom_idx),
    .entry      (rom_entry),
    .start_addr (rom_start)
  );

  assign accept = (state == ST_IDLE) && bus.play_req && !bus.abort;

`ifdef MELODY_SEQUENCER_LOOP_EN
  assign loop_id = (id_q == ID_SPIN);
`else
  assign loop_id = 1'b0;
`endif

  // dur 0 encodes 16 ticks
  assign play_len = (rom_entry.dur == '0) ? CNT_W'(PLAY_MAX)
                                          : CNT_W'(TICK_CYC) * CNT_W'(rom_entry.dur);
  assign gap_len  = (last_q && !loop_id) ? CNT_W'(GAP_CYC) : CNT_W'(GAP_CYC - 1);

  // sequencing FSM with shared note/gap down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      id_q       <= '0;
      idx        <= '0;
      div_q      <= '0;
      last_q     <= 1'b0;
      play_ack_q <= 1'b0;
    end else begin
      play_ack_q <= 1'b0;
      if (bus.abort && state != ST_IDLE) begin
        state <= ST_IDLE;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          ST_IDLE: if (accept) begin
            state      <= ST_LOAD;
            id_q       <= bus.play_id;
            idx        <= '0;
            play_ack_q <= 1'b1;
          end
          ST_LOAD: if (rom_start == ADDR_NONE) begin
            state <= ST_DONE;
          end else begin
            div_q  <= rom_entry.divider;
            last_q <= rom_entry.last;
            cnt    <= play_len;
            idx    <= rom_entry.last ? '0 : idx + 1'b1;
            state  <= ST_PLAY;
          end
          ST_PLAY: if (cnt <= CNT_ONE) begin
            cnt   <= gap_len;
            state <= ST_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
          ST_GAP: if (cnt <= CNT_ONE) begin
            cnt   <= '0;
            state <= (last_q && !loop_id) ? ST_DONE : ST_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.play_ack     = play_ack_q;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.done         = (state == ST_DONE);
  assign bus.tone_on      = (state == ST_PLAY) && (div_q != '0);
  assign bus.tone_divider = (state == ST_PLAY) ? 32'(div_q) : 32'd0;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer with TICK_CYC=4, GAP_CYC=2. Stimulus pushes the
// expected per-cycle outputs into a queue; a monitor pops one entry per cycle
// and compares.
module tb_melody_sequencer;
  import melody_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  melody_sequencer_if bus ();

  melody_sequencer #(.TICK_CYC(4), .GAP_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic        ack;
    logic        busy;
    logic        done;
    logic        ton;
    logic [31:0] div;
  } smp_t;

  smp_t  exp_q[$];
  string cur_tag;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic push(input logic ack, input logic busy, input logic done,
                      input logic [31:0] div, input int n);
    smp_t s;
    s.tag  = cur_tag;
    s.ack  = ack;
    s.busy = busy;
    s.done = done;
    s.ton  = (div != 32'd0);
    s.div  = div;
    for (int i = 0; i < n; i++) exp_q.push_back(s);
  endtask

  // LOAD, PLAY for dur ticks of 4 cycles, then the 1- or 2-cycle GAP, and DONE after the last
  task automatic push_note(input logic ack, input logic [31:0] div, input int dur, input bit last);
    push(ack, 1'b1, 1'b0, 32'd0, 1);
    push(1'b0, 1'b1, 1'b0, div, dur * 4);
    push(1'b0, 1'b1, 1'b0, 32'd0, last ? 2 : 1);
    if (last) push(1'b0, 1'b1, 1'b1, 32'd0, 1);
  endtask

  task automatic push_win(input logic ack);
    push_note(ack,  32'd35000, 1, 1'b0);
    push_note(1'b0, 32'd50000, 1, 1'b0);
    push_note(1'b0, 32'd70000, 1, 1'b1);
  endtask

  task automatic push_idle(input int n);
    push(1'b0, 1'b0, 1'b0, 32'd0, n);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout, %0d expected samples left, required 0", cur_tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // monitor: one expected sample per cycle, sampled 1 time unit after the edge
  initial begin
    smp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.play_ack !== e.ack || bus.busy !== e.busy || bus.done !== e.done ||
            bus.tone_on !== e.ton || bus.tone_divider !== e.div) begin
          n_fail++;
          $display("FAIL %s @%0t: got ack=%b busy=%b done=%b tone_on=%b div=%0d, required ack=%b busy=%b done=%b tone_on=%b div=%0d",
                   e.tag, $time, bus.play_ack, bus.busy, bus.done, bus.tone_on, bus.tone_divider,
                   e.ack, e.busy, e.done, e.ton, e.div);
        end
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.play_req = 1'b0;
    bus.play_id  = '0;
    bus.abort    = 1'b0;

    // reset state
    cur_tag = "reset";
    @(negedge clk);
    push_idle(3);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_drain();

    // id1: ack N+1, three notes, done N+20, idle N+21
    cur_tag = "win";
    @(negedge clk);
    bus.play_req = 1'b1;
    bus.play_id  = 3'd1;
    push_win(1'b1);
    push_idle(2);
    @(negedge clk);
    bus.play_req = 1'b0;
    wait_drain();

    // id2: 90000 / rest / 90000 at 8 ticks each
    cur_tag = "lose";
    @(negedge clk);
    bus.play_req = 1'b1;
    bus.play_id  = 3'd2;
    push_note(1'b1, 32'd90000, 8, 1'b0);
    push_note(1'b0, 32'd0,     8, 1'b0);
    push_note(1'b0, 32'd90000, 8, 1'b1);
    push_idle(2);
    @(negedge clk);
    bus.play_req = 1'b0;
    wait_drain();

    // id3: abort at edge N+22 (third cycle of second note)
    cur_tag = "clear_abort";
    @(negedge clk);
    bus.play_req = 1'b1;
    bus.play_id  = 3'd3;
    push_note(1'b1, 32'd30000, 4, 1'b0);
    push(1'b0, 1'b1, 1'b0, 32'd0, 1);
    push(1'b0, 1'b1, 1'b0, 32'd35000, 3);
    push_idle(5);
    @(negedge clk);
    bus.play_req = 1'b0;
    repeat (21) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_drain();

    // id1 with play_req held: second ack on first idle cycle (N+22)
    cur_tag = "held_req";
    @(negedge clk);
    bus.play_req = 1'b1;
    bus.play_id  = 3'd1;
    push_win(1'b1);
    push_idle(1);
    push_win(1'b1);
    push_idle(2);
    repeat (22) @(negedge clk);
    bus.play_req = 1'b0;
    wait_drain();

    // id5: ack, done two cycles after the request edge, no tone
    cur_tag = "id5";
    @(negedge clk);
    bus.play_req = 1'b1;
    bus.play_id  = 3'd5;
    push(1'b1, 1'b1, 1'b0, 32'd0, 1);
    push(1'b0, 1'b1, 1'b1, 32'd0, 1);
    push_idle(2);
    @(negedge clk);
    bus.play_req = 1'b0;
    wait_drain();

    // abort and request together in idle: no ack
    cur_tag = "abort_req_idle";
    @(negedge clk);
    bus.play_req = 1'b1;
    bus.abort    = 1'b1;
    bus.play_id  = 3'd1;
    push_idle(3);
    @(negedge clk);
    bus.play_req = 1'b0;
    bus.abort    = 1'b0;
    wait_drain();

`ifdef MELODY_SEQUENCER_LOOP_EN
    // id0 loops: 4 on / 2 off for ~100 cycles, no done, then abort
    cur_tag = "spin_loop";
    @(negedge clk);
    bus.play_req = 1'b1;
    bus.play_id  = 3'd0;
    push(1'b1, 1'b1, 1'b0, 32'd0, 1);
    push(1'b0, 1'b1, 1'b0, 32'd50000, 4);
    for (int r = 0; r < 16; r++) begin
      push(1'b0, 1'b1, 1'b0, 32'd0, 2);
      push(1'b0, 1'b1, 1'b0, 32'd50000, 4);
    end
    push_idle(3);
    @(negedge clk);
    bus.play_req = 1'b0;
    repeat (100) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_drain();
`else
    // id0 plays once and ends with done
    cur_tag = "spin_once";
    @(negedge clk);
    bus.play_req = 1'b1;
    bus.play_id  = 3'd0;
    push_note(1'b1, 32'd50000, 1, 1'b1);
    push_idle(2);
    @(negedge clk);
    bus.play_req = 1'b0;
    wait_drain();
`endif

    // rst asserted mid-note: all outputs 0 on the next cycle
    cur_tag = "rst_mid_note";
    @(negedge clk);
    bus.play_req = 1'b1;
    bus.play_id  = 3'd1;
    push(1'b1, 1'b1, 1'b0, 32'd0, 1);
    push(1'b0, 1'b1, 1'b0, 32'd35000, 3);
    push_idle(3);
    @(negedge clk);
    bus.play_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_drain();

    // sequencer still usable after the reset
    cur_tag = "after_rst";
    @(negedge clk);
    bus.play_req = 1'b1;
    bus.play_id  = 3'd1;
    push_win(1'b1);
    push_idle(2);
    @(negedge clk);
    bus.play_req = 1'b0;
    wait_drain();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYC, default 131072, giving clk cycles per duration tick.
REQ-002 SHALL have parameter GAP_CYC, default 4096, giving silent clk cycles inserted after every note.
REQ-003 SHALL have port clk  input  1  the single 50 MHz clock.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port play_req  input  1  level request to start a melody.
REQ-006 SHALL have port play_id  input  3  melody selector, sampled with the accepted play_req.
REQ-007 SHALL have port abort  input  1  stops playback immediately.
REQ-008 SHALL have port play_ack  output  1  one-cycle pulse when a request is accepted.
REQ-009 SHALL have port busy  output  1  high from acceptance until the cycle after done.
REQ-010 SHALL have port done  output  1  one-cycle pulse at natural melody end.
REQ-011 SHALL have port tone_divider  output  32  half-period divider for the buzzer; 0 means silence.
REQ-012 SHALL have port tone_on  output  1  high while a non-rest note sounds.

Function
REQ-013 SHALL implement states IDLE, LOAD, PLAY, GAP, DONE.
REQ-014 SHALL accept a request only in IDLE: when play_req=1 at edge N, play_ack=1 and busy=1 in cycle N+1, and the state is LOAD.
REQ-015 SHALL ignore play_req while busy (no ack), and SHALL accept a still-held request on the first IDLE cycle afterwards.
REQ-016 SHALL read one registered ROM entry in LOAD: {last, divider[17:0], dur[3:0]}, and enter PLAY on the next cycle.
REQ-017 SHALL keep PLAY for dur*TICK_CYC cycles, with tone_divider set to the zero-extended divider and tone_on = (divider != 0).
REQ-018 SHALL treat dur=0 as dur=16.
REQ-019 SHALL then keep GAP for GAP_CYC cycles with tone_on=0 and tone_divider=0, then go to LOAD of the next entry, or to DONE if last=1.
REQ-020 SHALL pulse done in DONE for one cycle, then return to IDLE with busy=0.
REQ-021 SHALL define the melodies as follows:
  - id0 spin: 50000 dur1, last.
  - id1 win: 35000/50000/70000, dur1 each.
  - id2 lose: 90000 dur8, rest dur8, 90000 dur8.
  - id3 clear: 30000/35000/30000/45000, dur4 each.
REQ-022 SHALL, for ids 4-7, ack the request and go LOAD->DONE with no tone.
REQ-023 SHALL, on abort=1 in any busy state, go to IDLE on the next edge with tone_on=0, tone_divider=0, busy=0 and no done pulse.
REQ-024 SHALL give abort priority when abort and play_req coincide in IDLE, producing no ack.
REQ-025 SHALL size the duration counter so that it holds 16*TICK_CYC without wrap.

Reset
REQ-026 SHALL, when rst=1 at an edge, force state IDLE and set play_ack=0, busy=0, done=0, tone_divider=0, tone_on=0, and all counters to 0, including mid-note.

Configuration
REQ-027 SHALL, with MELODY_SEQUENCER_LOOP_EN defined, make id0 repeat (GAP->LOAD of the first entry instead of DONE) until abort, with no done pulse.
REQ-028 SHALL, without MELODY_SEQUENCER_LOOP_EN, play id0 once and end with done.

Structure
REQ-029 SHALL place the state encoding, melody id constants, ROM entry field widths and the divider note constants (30000, 35000, 45000, 50000, 70000, 90000) in a shared package melody_pkg.
REQ-030 SHALL implement the note table as sub-module melody_rom: inputs melody id and note index, registered output entry and start address.

Verification (TICK_CYC=4, GAP_CYC=2)
REQ-031 SHALL cover: play_req with id1 at edge N -> ack at N+1; tone_on high 4 cycles at 35000, 50000 and 70000 in turn, each followed by a 2-cycle gap; done at N+20; busy low at N+21.
REQ-032 SHALL cover: id2 -> divider 90000 for 32 cycles, then the rest (tone_on=0) for 32+2 cycles, then 90000 again; done pulses once.
REQ-033 SHALL cover: abort during the second note of id3 -> next cycle tone_on=0, busy=0; done never pulses.
REQ-034 SHALL cover: play_req held high during id1 playback -> no second ack until IDLE, then ack on the first IDLE cycle.
REQ-035 SHALL cover: id5 -> ack, done 2 cycles later, tone_on never high; abort and req in the same IDLE cycle -> no ack.
REQ-036 SHALL cover: with LOOP_EN defined, id0 -> 50000 pattern of 4 on / 2 off repeating over 100 cycles with no done; rst mid-note -> all outputs 0 on the next cycle.
